// File: rtl/unpack_arbiter_pkg.sv
// Shared definitions for the unpack arbiter: width helper and state encoding.
package unpack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index width for n items, never below one bit (IDXW, SRCW).
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unpack_arbiter_if.sv
// Requester and word-output channels of the unpack arbiter.
//   req_stb/req_dat/req_rdy : per-requester packed vector channel
//   out_stb/out_dat/out_src/out_lst/out_rdy : serialized word channel
// master = arbiter side, slave = requesters plus consumer.
interface unpack_arbiter_if
  import unpack_pkg::*;
#(
  parameter int ARGW = 8,
  parameter int ARGD = 2,
  parameter int NREQ = 4
);
  localparam int SRCW = clog2_min1(NREQ);

  logic [NREQ-1:0]           req_stb;
  logic [NREQ*ARGD*ARGW-1:0] req_dat;
  logic [NREQ-1:0]           req_rdy;
  logic                      out_stb;
  logic [ARGW-1:0]           out_dat;
  logic [SRCW-1:0]           out_src;
  logic                      out_lst;
  logic                      out_rdy;

  modport master (
    input  req_stb, req_dat, out_rdy,
    output req_rdy, out_stb, out_dat, out_src, out_lst
  );

  modport slave (
    output req_stb, req_dat, out_rdy,
    input  req_rdy, out_stb, out_dat, out_src, out_lst
  );
endinterface

// File: rtl/unpack_arbiter_rr.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// wrapping around.
//   req     : request vector
//   ptr     : highest-priority index (always < NREQ)
//   gnt     : one-hot grant, zero when nothing requests
//   gnt_idx : binary index of the grant
//   any     : some request present
module rr_arbiter
  import unpack_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int SRCW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SRCW-1:0] gnt_idx,
  output logic            any
);

  int              pos;
  logic [NREQ-1:0] req_sh;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = 0;
    req_sh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      req_sh = req >> pos;
      if (!any && req_sh[0]) begin
        any     = 1'b1;
        gnt     = NREQ'(1) << pos;
        gnt_idx = SRCW'(pos);
      end
    end
  end

endmodule

// File: rtl/unpack_arbiter.sv
// Round-robin arbiter that takes one packed ARGD*ARGW vector from one of
// NREQ requesters and emits it as ARGD words, LSB word first, each tagged
// with source index and last flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester and word channels (master side)
//
// state | meaning
// IDLE  | no vector held, out_stb low, any request may be taken
// BUSY  | vector held, out_stb high, word idx on out_dat
module unpack_arbiter
  import unpack_pkg::*;
#(
  parameter int ARGW = 8,
  parameter int ARGD = 2,
  parameter int NREQ = 4
) (
  input logic              clk,
  input logic              rst_n,
  unpack_arbiter_if.master bus
);

  localparam int VW   = ARGD * ARGW;
  localparam int IDXW = clog2_min1(ARGD);
  localparam int SRCW = clog2_min1(NREQ);

  state_t                      state;
  logic [ARGD-1:0][ARGW-1:0]   hold;
  logic [IDXW-1:0]             idx;
  logic [IDXW-1:0]             idx_nxt;
  logic [SRCW-1:0]             ptr;
  logic [NREQ-1:0][VW-1:0]     req_vec;
  logic [NREQ-1:0]             gnt;
  logic [SRCW-1:0]             gnt_idx;
  logic                        any;
  logic                        acc;
  logic                        take;

  assign req_vec = bus.req_dat;
  assign idx_nxt = idx + IDXW'(1);

  // A new vector may enter when idle or in the very cycle the last word
  // leaves, which keeps back-to-back vectors bubble-free.
  assign acc  = (state == IDLE) || (bus.out_lst && bus.out_rdy);
  assign take = acc && any;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (bus.req_stb),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign bus.req_rdy = (acc && rst_n) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      idx         <= '0;
      ptr         <= '0;
      bus.out_stb <= 1'b0;
      bus.out_dat <= '0;
      bus.out_src <= '0;
      bus.out_lst <= 1'b0;
    end else if (take) begin
      hold        <= req_vec[gnt_idx];
      bus.out_dat <= req_vec[gnt_idx][ARGW-1:0];
      bus.out_src <= gnt_idx;
      bus.out_lst <= (ARGD == 1);
      bus.out_stb <= 1'b1;
      idx         <= '0;
      ptr         <= (gnt_idx == SRCW'(NREQ - 1)) ? '0 : gnt_idx + SRCW'(1);
      state       <= BUSY;
    end else if (state == BUSY && bus.out_rdy) begin
      if (bus.out_lst) begin
        bus.out_stb <= 1'b0;
        state       <= IDLE;
      end else begin
        idx         <= idx_nxt;
        bus.out_dat <= hold[idx_nxt];
        bus.out_lst <= (idx_nxt == IDXW'(ARGD - 1));
      end
    end
  end

endmodule

// File: tb/tb_unpack_arbiter.sv
module tb_unpack_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  unpack_arbiter_if #(.ARGW(8), .ARGD(2), .NREQ(4)) ifa ();
  unpack_arbiter_if #(.ARGW(8), .ARGD(1), .NREQ(3)) ifb ();

  unpack_arbiter #(.ARGW(8), .ARGD(2), .NREQ(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  unpack_arbiter #(.ARGW(8), .ARGD(1), .NREQ(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  stb;
    logic [63:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_stb;
    logic [7:0]  e_dat;
    logic [1:0]  e_src;
    logic        e_lst;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   cur   = -1;

  function automatic logic [63:0] mk(input logic [15:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic vec_t row(input logic rs, input logic [3:0] stb, input logic [63:0] dat,
                               input logic ordy, input logic [3:0] e_rdy, input logic e_stb,
                               input logic [7:0] e_dat, input logic [1:0] e_src, input logic e_lst);
    vec_t v;
    v.rst = rs; v.stb = stb; v.dat = dat; v.ordy = ordy; v.e_rdy = e_rdy;
    v.e_stb = e_stb; v.e_dat = e_dat; v.e_src = e_src; v.e_lst = e_lst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d t=%0t): got %0h expected %0h", nm, cur, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    if (v.rst) begin
      rst_n = 1'b0;
      ifa.req_stb = '0;
      #2;
      rst_n = 1'b1;
    end
    ifa.req_stb = v.stb;
    ifa.req_dat = v.dat;
    ifa.out_rdy = v.ordy;
    @(negedge clk);
    chk("req_rdy", 64'(ifa.req_rdy), 64'(v.e_rdy));
    chk("out_stb", 64'(ifa.out_stb), 64'(v.e_stb));
    if (v.e_stb) begin
      chk("out_dat", 64'(ifa.out_dat), 64'(v.e_dat));
      chk("out_src", 64'(ifa.out_src), 64'(v.e_src));
      chk("out_lst", 64'(ifa.out_lst), 64'(v.e_lst));
    end
  endtask

  task automatic run_tab(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cur = i;
      apply(vq[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d1, d2, d3a, d3b, d4a, d4b, d4c, d5a, d5b;
    logic [7:0]  bdat [3];
    int          n1;

    d1  = mk(16'h0000, 16'hBEEF, 16'h0000, 16'h0000);
    d2  = mk(16'h0201, 16'h1211, 16'h2221, 16'h3231);
    d3a = mk(16'h0000, 16'h0000, 16'h0000, 16'hC3D4);
    d3b = mk(16'h7788, 16'h0000, 16'h0000, 16'hC3D4);
    d4a = mk(16'h0000, 16'h0000, 16'h1A2B, 16'h0000);
    d4b = mk(16'h0000, 16'h0000, 16'h3C4D, 16'h0000);
    d4c = mk(16'h0000, 16'h0000, 16'h5E6F, 16'h0000);
    d5a = mk(16'h0000, 16'h9988, 16'h0000, 16'h0000);
    d5b = mk(16'h0F0E, 16'h0000, 16'h0000, 16'h3F3E);

    // single vector from req1
    vq.push_back(row(0, 4'b0010, d1, 1, 4'b0010, 0, 8'h00, 0, 0));
    vq.push_back(row(0, 4'b0000, d1, 1, 4'b0000, 1, 8'hEF, 1, 0));
    vq.push_back(row(0, 4'b0000, d1, 1, 4'b0000, 1, 8'hBE, 1, 1));
    vq.push_back(row(0, 4'b0000, d1, 1, 4'b0000, 0, 8'h00, 0, 0));
    // all four requesting after reset: rotation with no bubble
    vq.push_back(row(1, 4'b1111, d2, 1, 4'b0001, 0, 8'h00, 0, 0));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0000, 1, 8'h01, 0, 0));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0010, 1, 8'h02, 0, 1));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0000, 1, 8'h11, 1, 0));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0100, 1, 8'h12, 1, 1));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0000, 1, 8'h21, 2, 0));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b1000, 1, 8'h22, 2, 1));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0000, 1, 8'h31, 3, 0));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0001, 1, 8'h32, 3, 1));
    vq.push_back(row(0, 4'b1111, d2, 1, 4'b0000, 1, 8'h01, 0, 0));
    vq.push_back(row(0, 4'b0000, d2, 1, 4'b0000, 1, 8'h02, 0, 1));
    vq.push_back(row(0, 4'b0000, d2, 1, 4'b0000, 0, 8'h00, 0, 0));
    // stall five cycles on word 0 of req3 (ptr=1), req0 waiting meanwhile
    vq.push_back(row(0, 4'b1000, d3a, 1, 4'b1000, 0, 8'h00, 0, 0));
    vq.push_back(row(0, 4'b0000, d3a, 0, 4'b0000, 1, 8'hD4, 3, 0));
    vq.push_back(row(0, 4'b0000, d3a, 0, 4'b0000, 1, 8'hD4, 3, 0));
    vq.push_back(row(0, 4'b0001, d3b, 0, 4'b0000, 1, 8'hD4, 3, 0));
    vq.push_back(row(0, 4'b0001, d3b, 0, 4'b0000, 1, 8'hD4, 3, 0));
    vq.push_back(row(0, 4'b0001, d3b, 0, 4'b0000, 1, 8'hD4, 3, 0));
    vq.push_back(row(0, 4'b0001, d3b, 1, 4'b0000, 1, 8'hD4, 3, 0));
    vq.push_back(row(0, 4'b0001, d3b, 0, 4'b0000, 1, 8'hC3, 3, 1));
    vq.push_back(row(0, 4'b0001, d3b, 1, 4'b0001, 1, 8'hC3, 3, 1));
    vq.push_back(row(0, 4'b0000, d3b, 1, 4'b0000, 1, 8'h88, 0, 0));
    vq.push_back(row(0, 4'b0000, d3b, 1, 4'b0000, 1, 8'h77, 0, 1));
    vq.push_back(row(0, 4'b0000, d3b, 1, 4'b0000, 0, 8'h00, 0, 0));
    // req2 alone, three vectors back to back (ptr=1)
    vq.push_back(row(0, 4'b0100, d4a, 1, 4'b0100, 0, 8'h00, 0, 0));
    vq.push_back(row(0, 4'b0100, d4b, 1, 4'b0000, 1, 8'h2B, 2, 0));
    vq.push_back(row(0, 4'b0100, d4b, 1, 4'b0100, 1, 8'h1A, 2, 1));
    vq.push_back(row(0, 4'b0100, d4c, 1, 4'b0000, 1, 8'h4D, 2, 0));
    vq.push_back(row(0, 4'b0100, d4c, 1, 4'b0100, 1, 8'h3C, 2, 1));
    vq.push_back(row(0, 4'b0000, d4c, 1, 4'b0000, 1, 8'h6F, 2, 0));
    vq.push_back(row(0, 4'b0000, d4c, 1, 4'b0000, 1, 8'h5E, 2, 1));
    vq.push_back(row(0, 4'b0000, d4c, 1, 4'b0000, 0, 8'h00, 0, 0));
    n1 = vq.size();
    // after mid-vector reset: req0 then req3
    vq.push_back(row(0, 4'b1000, d5b, 1, 4'b0000, 1, 8'h0E, 0, 0));
    vq.push_back(row(0, 4'b1000, d5b, 1, 4'b1000, 1, 8'h0F, 0, 1));
    vq.push_back(row(0, 4'b0000, d5b, 1, 4'b0000, 1, 8'h3E, 3, 0));
    vq.push_back(row(0, 4'b0000, d5b, 1, 4'b0000, 1, 8'h3F, 3, 1));
    vq.push_back(row(0, 4'b0000, d5b, 1, 4'b0000, 0, 8'h00, 0, 0));

    rst_n       = 1'b0;
    ifa.req_stb = '0;
    ifa.req_dat = '0;
    ifa.out_rdy = 1'b1;
    ifb.req_stb = '0;
    ifb.req_dat = '0;
    ifb.out_rdy = 1'b1;
    #3;
    chk("rst_out_stb", 64'(ifa.out_stb), 64'd0);
    chk("rst_out_dat", 64'(ifa.out_dat), 64'd0);
    chk("rst_out_src", 64'(ifa.out_src), 64'd0);
    chk("rst_out_lst", 64'(ifa.out_lst), 64'd0);
    #9;
    rst_n = 1'b1;

    run_tab(0, n1);

    // asynchronous reset in the middle of word 0 (ptr=3 so req1 wins)
    cur = -5;
    @(posedge clk); #1;
    ifa.req_stb = 4'b0010; ifa.req_dat = d5a; ifa.out_rdy = 1'b0;
    @(negedge clk);
    chk("t5_rdy_pre", 64'(ifa.req_rdy), 64'b0010);
    @(posedge clk); #1;
    ifa.req_stb = 4'b1001; ifa.req_dat = d5b;
    #1;
    chk("t5_stb_pre", 64'(ifa.out_stb), 64'd1);
    chk("t5_dat_pre", 64'(ifa.out_dat), 64'h88);
    chk("t5_src_pre", 64'(ifa.out_src), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_stb_rst", 64'(ifa.out_stb), 64'd0);
    chk("t5_dat_rst", 64'(ifa.out_dat), 64'd0);
    chk("t5_src_rst", 64'(ifa.out_src), 64'd0);
    chk("t5_lst_rst", 64'(ifa.out_lst), 64'd0);
    chk("t5_rdy_rst", 64'(ifa.req_rdy), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ifa.out_rdy = 1'b1;
    #1;
    chk("t5_rdy_rel", 64'(ifa.req_rdy), 64'b0001);
    chk("t5_stb_rel", 64'(ifa.out_stb), 64'd0);
    run_tab(n1, vq.size());

    // ARGD=1, NREQ=3 instance: one word per cycle, always last
    bdat[0] = 8'hA0; bdat[1] = 8'hB1; bdat[2] = 8'hC2;
    cur = -6;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      ifb.req_stb = 3'b111;
      ifb.req_dat = {bdat[2], bdat[1], bdat[0]};
      @(negedge clk);
      chk("b_req_rdy", 64'(ifb.req_rdy), 64'(3'b001 << (k % 3)));
      chk("b_out_stb", 64'(ifb.out_stb), (k > 0) ? 64'd1 : 64'd0);
      if (k > 0) begin
        chk("b_out_src", 64'(ifb.out_src), 64'((k - 1) % 3));
        chk("b_out_dat", 64'(ifb.out_dat), 64'(bdat[(k - 1) % 3]));
        chk("b_out_lst", 64'(ifb.out_lst), 64'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
